fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline. Owns the PC, issues instruction requests to the icache, and presents the fetched word to the IF/ID pipeline register.
- Inputs that steer it:
  - branch/jump redirects from later stages;
  - IF/ID stall (hazard unit);
  - halt.
- A one-entry hold buffer keeps an icache hit that arrives while IF/ID is stalled, so the instruction is not lost and not refetched.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/pc_reg.sv | 33 +++
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared CPU types and constants for the pipeline stages
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    localparam opcode_t RTYPE   = 6'h00;
    localparam word_t   PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    function automatic opcode_t opcode_of(input word_t instr);
        return instr[31:26];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// pc_reg : program counter register with async active-low reset and load enable
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_reg
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_load,
    input  word_t i_d,
    output word_t o_q
);

    word_t r_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= PC_INIT;
        end else if (i_load) begin
            r_pc <= i_d;
        end
    end

    assign o_q = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : IF stage - owns the PC, requests the icache, feeds IF/ID
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fetch_valid,
    output logic        fetch_flush,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pcinc,
    output logic [5:0]  fetch_opcode
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    word_t w_pc;
    word_t w_pc_inc;
    word_t w_pc_next;
    logic  w_pc_load;

    word_t r_buf;
    word_t r_bufpc;
    logic  w_buf_load;
    logic  w_buf_drop;

    assign w_pc_inc = w_pc + PC_STEP;

    pc_reg #(
        .PC_INIT (PC_INIT)
    ) u_pc_reg (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_load  (w_pc_load),
        .i_d     (w_pc_next),
        .o_q     (w_pc)
    );

    // Next-PC selection: halt freezes the PC, redirect beats the sequential step.
    always_comb begin
        w_pc_load = 1'b0;
        w_pc_next = w_pc;
        if (r_state != HALTED && !halt) begin
            if (redirect) begin
                w_pc_load = 1'b1;
                w_pc_next = redirect_pc;
            end else if (r_state == RUN && ihit) begin
                w_pc_load = 1'b1;
                w_pc_next = w_pc_inc;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN: begin
                if (halt)
                    w_next_state = HALTED;
                else if (redirect)
                    w_next_state = RUN;
                else if (ihit && stall)
                    w_next_state = HOLD;
            end
            HOLD: begin
                if (halt)
                    w_next_state = HALTED;
                else if (redirect || !stall)
                    w_next_state = RUN;
            end
            default: w_next_state = HALTED;
        endcase
    end

    // Outputs are forced to their idle values while nRST is low, so a hit
    // arriving during reset is never presented to IF/ID.
    always_comb begin
        imemREN     = 1'b0;
        fetch_valid = 1'b0;
        fetch_flush = 1'b0;
        fetch_instr = '0;
        fetch_pcinc = '0;
        w_buf_load  = 1'b0;
        w_buf_drop  = 1'b0;
        if (!nRST) begin
            imemREN = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    imemREN = 1'b1;
                    if (!halt) begin
                        if (redirect) begin
                            fetch_flush = 1'b1;
                        end else if (ihit && !stall) begin
                            fetch_valid = 1'b1;
                            fetch_instr = imemload;
                            fetch_pcinc = w_pc_inc;
                        end else if (ihit) begin
                            w_buf_load = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    fetch_instr = r_buf;
                    fetch_pcinc = r_bufpc;
                    if (!halt) begin
                        if (redirect) begin
                            fetch_flush = 1'b1;
                            w_buf_drop  = 1'b1;
                        end else begin
                            fetch_valid = !stall;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_buf   <= '0;
            r_bufpc <= '0;
        end else if (w_buf_load) begin
            r_buf   <= imemload;
            r_bufpc <= w_pc_inc;
        end else if (w_buf_drop) begin
            r_buf   <= '0;
            r_bufpc <= '0;
        end
    end

    assign imemaddr     = w_pc;
    assign fetch_opcode = opcode_of(fetch_instr);

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed self-checking bench for fetch_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fetch_valid;
    logic        fetch_flush;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pcinc;
    logic [5:0]  fetch_opcode;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage #(
        .PC_INIT (32'h0000_0000)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .imemload     (imemload),
        .imemREN      (imemREN),
        .imemaddr     (imemaddr),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .fetch_valid  (fetch_valid),
        .fetch_flush  (fetch_flush),
        .fetch_instr  (fetch_instr),
        .fetch_pcinc  (fetch_pcinc),
        .fetch_opcode (fetch_opcode)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic h, input logic s, input logic r, input logic [31:0] rpc,
                         input logic hl, input logic [31:0] ld);
        ihit        = h;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        halt        = hl;
        imemload    = ld;
        #2;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h2001_0005);
        check("rst_ren",    {31'b0, imemREN},     32'h1);
        check("rst_addr",   imemaddr,             32'h0);
        check("rst_valid",  {31'b0, fetch_valid}, 32'h0);
        check("rst_flush",  {31'b0, fetch_flush}, 32'h0);
        check("rst_instr",  fetch_instr,          32'h0);
        check("rst_pcinc",  fetch_pcinc,          32'h0);
        check("rst_opcode", {26'b0, fetch_opcode}, 32'h0);
        tick();
        nRST = 1'b1;

        // Streaming hits
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h2001_0005);
        check("s0_addr",   imemaddr,              32'h0);
        check("s0_valid",  {31'b0, fetch_valid},  32'h1);
        check("s0_instr",  fetch_instr,           32'h2001_0005);
        check("s0_pcinc",  fetch_pcinc,           32'h4);
        check("s0_opcode", {26'b0, fetch_opcode}, 32'h08);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0020);
        check("s1_addr",   imemaddr,              32'h4);
        check("s1_valid",  {31'b0, fetch_valid},  32'h1);
        check("s1_pcinc",  fetch_pcinc,           32'h8);
        check("s1_opcode", {26'b0, fetch_opcode}, 32'h00);
        tick();

        // Hit under stall goes to the hold buffer
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'hAC22_0000);
        check("st_addr",  imemaddr,             32'h8);
        check("st_ren",   {31'b0, imemREN},     32'h1);
        check("st_valid", {31'b0, fetch_valid}, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
            check("hold_ren",   {31'b0, imemREN},     32'h0);
            check("hold_valid", {31'b0, fetch_valid}, 32'h0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        check("rel_valid", {31'b0, fetch_valid}, 32'h1);
        check("rel_instr", fetch_instr,          32'hAC22_0000);
        check("rel_pcinc", fetch_pcinc,          32'hC);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rel_next_addr", imemaddr,         32'hC);
        check("rel_next_ren",  {31'b0, imemREN}, 32'h1);
        tick();

        // Redirect alongside a hit, then alongside a hit under stall
        drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h1111_1111);
        check("rd_flush", {31'b0, fetch_flush}, 32'h1);
        check("rd_valid", {31'b0, fetch_valid}, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rd_addr",    imemaddr,             32'h40);
        check("rd_unflush", {31'b0, fetch_flush}, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h2222_2222);
        check("rds_flush", {31'b0, fetch_flush}, 32'h1);
        check("rds_valid", {31'b0, fetch_valid}, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rds_addr", imemaddr,         32'h80);
        check("rds_ren",  {31'b0, imemREN}, 32'h1);
        tick();

        // Redirect while holding drops the buffer
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h1234_5678);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        check("rdh_ren",   {31'b0, imemREN},     32'h0);
        check("rdh_flush", {31'b0, fetch_flush}, 32'h1);
        check("rdh_valid", {31'b0, fetch_valid}, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rdh_addr",   imemaddr,             32'h40);
        check("rdh_run",    {31'b0, imemREN},     32'h1);
        check("rdh_nvalid", {31'b0, fetch_valid}, 32'h0);
        tick();

        // PC wrap
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8C01_0000);
        check("wrap_addr",   imemaddr,              32'hFFFF_FFFC);
        check("wrap_valid",  {31'b0, fetch_valid},  32'h1);
        check("wrap_pcinc",  fetch_pcinc,           32'h0);
        check("wrap_opcode", {26'b0, fetch_opcode}, 32'h23);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("wrap_next", imemaddr, 32'h0);
        tick();

        // No hit: PC holds
        drive(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h3C01_0001);
            check("miss_addr",  imemaddr,             32'h10);
            check("miss_valid", {31'b0, fetch_valid}, 32'h0);
            tick();
        end

        // Asynchronous reset mid-cycle
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h3C01_0001);
        check("pre_arst_valid", {31'b0, fetch_valid}, 32'h1);
        #2;
        nRST = 1'b0;
        #1;
        check("arst_addr",  imemaddr,             32'h0);
        check("arst_valid", {31'b0, fetch_valid}, 32'h0);
        check("arst_instr", fetch_instr,          32'h0);
        check("arst_ren",   {31'b0, imemREN},     32'h1);
        tick();
        nRST = 1'b1;

        // Halt
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h2001_0005);
        check("h_pre_valid", {31'b0, fetch_valid}, 32'h1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h2001_0006);
        check("h_valid", {31'b0, fetch_valid}, 32'h0);
        check("h_flush", {31'b0, fetch_flush}, 32'h0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h2001_0007);
            check("halted_addr",  imemaddr,             32'h4);
            check("halted_ren",   {31'b0, imemREN},     32'h0);
            check("halted_valid", {31'b0, fetch_valid}, 32'h0);
            tick();
        end
        nRST = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("h_rst_addr", imemaddr, 32'h0);
        tick();
        nRST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("h_rst_ren", {31'b0, imemREN}, 32'h1);

        // Halt together with redirect: halt wins
        drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h2001_0005);
        check("hr_flush", {31'b0, fetch_flush}, 32'h0);
        check("hr_valid", {31'b0, fetch_valid}, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("hr_addr", imemaddr,         32'h0);
        check("hr_ren",  {31'b0, imemREN}, 32'h0);
        tick();
        nRST = 1'b0;
        #1;
        check("end_rst_addr", imemaddr,         32'h0);
        check("end_rst_ren",  {31'b0, imemREN}, 32'h1);
        tick();
        nRST = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
